// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first parallel-to-serial shifter with per-word length, back-to-back capable.
module serial_pattern_gen #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         DIN,
    input  logic [$clog2(WIDTH):0]   LEN,
    input  logic                     VALID,
    output logic                     READY,
    output logic                     X,
    output logic                     BUSY,
    output logic                     DONE
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0] cnt, eff_len;
    logic last, transfer;
    always_comb begin
        last = state == SHIFT && cnt == CW'(1);
        READY = state == IDLE || last;
        transfer = VALID && READY;
        eff_len = (LEN == '0 || LEN > CW'(WIDTH)) ? CW'(WIDTH) : LEN;
        state_n = transfer ? SHIFT : (last ? IDLE : state);
        BUSY = state == SHIFT;
        DONE = last;
    end
    // cnt holds the bits still to send including the one on X; it stops at 1 and never wraps
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sh <= '0;
            cnt <= '0;
            X <= IDLE_LEVEL;
        end else begin
            state <= state_n;
            if (transfer) begin
                X <= DIN[WIDTH-1];
                sh <= DIN << 1;
                cnt <= eff_len;
            end else if (last) begin
                X <= IDLE_LEVEL;
                cnt <= '0;
            end else if (state == SHIFT) begin
                X <= sh[WIDTH-1];
                sh <= sh << 1;
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: doc/serial_pattern_gen.md
SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (range 2..32).
REQ-002 The block SHALL have parameter IDLE_LEVEL, default 1'b0, giving the X level driven while no bit is being sent.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port DIN  input  WIDTH  parallel word, sent MSB first.
REQ-006 The block SHALL have port LEN  input  ceil(log2(WIDTH))+1  number of bits to send; 0 and any value above WIDTH mean WIDTH.
REQ-007 The block SHALL have port VALID  input  1  source offers DIN/LEN this cycle.
REQ-008 The block SHALL have port READY  output  1  block accepts a word this cycle.
REQ-009 The block SHALL have port X  output  1  registered serial bit stream, driving the sequence detector's serial input directly.
REQ-010 The block SHALL have port BUSY  output  1  high in every cycle in which X carries a data bit.
REQ-011 The block SHALL have port DONE  output  1  one-cycle pulse in the cycle the last bit of a word is on X.

Function
REQ-012 A transfer SHALL occur at a rising edge where VALID=1, READY=1 and RST=0; DIN and LEN are captured at that edge.
REQ-013 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-014 IDLE transitions SHALL be: to SHIFT on a transfer; otherwise stay in IDLE.
REQ-015 SHIFT transitions SHALL be: on the last bit with a transfer, stay in SHIFT and load the new word; on the last bit with no transfer, go to IDLE; otherwise stay in SHIFT.
REQ-016 READY SHALL be combinational and equal (state==IDLE) OR (state==SHIFT AND current bit is the last bit).
REQ-017 For a transfer at edge k with effective length N, X SHALL equal DIN[WIDTH-1-i] during the cycle following edge k+i, for i = 0..N-1.
REQ-018 Latency SHALL be exactly one cycle: the first bit appears immediately after the accepting edge.
REQ-019 BUSY SHALL be 1 exactly in the N bit cycles of each word.
REQ-020 DONE SHALL be 1 exactly in the bit cycle carrying DIN[WIDTH-N].
REQ-021 When READY=1 in the last-bit cycle and VALID=1, the next word SHALL follow with no gap cycle; BUSY stays 1 and DONE pulses once per word.
REQ-022 When no word follows, X SHALL return to IDLE_LEVEL and BUSY to 0 at edge k+N.
REQ-023 VALID asserted while READY=0 SHALL be ignored without side effects; the source holds DIN/LEN until READY=1.
REQ-024 A bit counter of ceil(log2(WIDTH))+1 bits SHALL count remaining bits, with no wrap-around; the last bit is the one where the count equals 1.
REQ-025 A word with N=1 SHALL produce one bit cycle in which BUSY=1, DONE=1 and READY=1.
REQ-026 DIN bits below WIDTH-N SHALL NOT affect X.

Reset
REQ-027 After any edge with RST=1, the outputs SHALL be X=IDLE_LEVEL, BUSY=0, DONE=0, READY=1, with state IDLE and the counter cleared.
REQ-028 RST SHALL take priority over VALID on the same edge; no transfer occurs.
REQ-029 RST during SHIFT SHALL abort the word immediately with no DONE pulse; the remaining bits are discarded.
REQ-030 While RST=1, X, BUSY and DONE SHALL remain at their reset values.

Verification
REQ-031 The bench SHALL cover: RST=1 for 2 edges with VALID=1 and DIN=8'hFF -> X=0, BUSY=0, DONE=0, no bits sent; READY=1 after release.
REQ-032 The bench SHALL cover: DIN=8'b1011_0010, LEN=8, VALID for one cycle -> X=1,0,1,1,0,0,1,0 on 8 consecutive cycles, BUSY high for 8 cycles, DONE on the 8th cycle, then X=0.
REQ-033 The bench SHALL cover: DIN=8'b1100_0000 with LEN=3, then with LEN=0 -> 1,1,0 with DONE on bit 3, then 8 bits 1,1,0,0,0,0,0,0.
REQ-034 The bench SHALL cover: VALID held with 8'hF0 then 8'h0F, both LEN=4 -> X=1,1,1,1,0,0,0,0 with no gap, BUSY continuous for 8 cycles, DONE on bits 4 and 8.
REQ-035 The bench SHALL cover: VALID raised in bit 2 of an 8-bit word -> READY=0 until bit 8, and the new word's first bit appears in cycle 9.
REQ-036 The bench SHALL cover: RST pulsed after 3 bits of 8'hFF -> X=0 and BUSY=0 in the next cycle, no DONE, and a new word is accepted normally afterwards.
